// File: rtl/serial_compare_controller.sv
// serial_compare_controller
//   Compares two unsigned WIDTH-bit operands one nibble per clock, most
//   significant nibble first. The comparison stops as soon as a nibble
//   differs, or after nibble 0 has been evaluated.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         request a comparison (accepted only while ready=1)
//   a, b          operands, captured on the accepting edge
//   abort         cancel a comparison in progress (RUN only)
//   result_ack    consumer has taken the result (DONE only)
//   ready         high in IDLE
//   busy          high in RUN
//   result_valid  high in DONE
//   a_gt_b, a_eq_b, a_lt_b  one-hot comparison result, zero outside DONE
//   nib_used      number of nibbles evaluated for the presented result
module serial_compare_controller #(
   parameter int WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [WIDTH-1:0]             a,
   input  logic [WIDTH-1:0]             b,
   input  logic                         abort,
   input  logic                         result_ack,
   output logic                         ready,
   output logic                         busy,
   output logic                         result_valid,
   output logic                         a_gt_b,
   output logic                         a_eq_b,
   output logic                         a_lt_b,
   output logic [$clog2(WIDTH/4):0]     nib_used
);

   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam int NW  = $clog2(NIB) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] a_r, b_r;
   logic             gt_r, eq_r;
   logic [IW-1:0]    idx;

   logic [3:0]       a_nib, b_nib;
   logic             gt_n, eq_n;
   logic             last;
   logic [NW-1:0]    m;

   // Current nibble and the magnitude cascade across its four bits, MSB first.
   always_comb begin
      a_nib = a_r[{idx, 2'b00} +: 4];
      b_nib = b_r[{idx, 2'b00} +: 4];
      gt_n  = gt_r;
      eq_n  = eq_r;
      for (int unsigned k = 0; k < 4; k++) begin
         gt_n = gt_n | (eq_n & a_nib[3-k] & ~b_nib[3-k]);
         eq_n = eq_n & ~(a_nib[3-k] ^ b_nib[3-k]);
      end
      last = (idx == '0) | ~eq_n;
      m    = NW'(NIB - int'(idx));
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (start) state_n = RUN;
         RUN: begin
            // abort wins over a comparison that would otherwise finish now
            if (abort)     state_n = IDLE;
            else if (last) state_n = DONE;
         end
         DONE: if (result_ack) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r      <= '0;
         b_r      <= '0;
         gt_r     <= 1'b0;
         eq_r     <= 1'b0;
         idx      <= '0;
         a_gt_b   <= 1'b0;
         a_eq_b   <= 1'b0;
         a_lt_b   <= 1'b0;
         nib_used <= '0;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               a_r  <= a;
               b_r  <= b;
               gt_r <= 1'b0;
               eq_r <= 1'b1;
               idx  <= IW'(NIB - 1);
            end
            RUN: if (!abort) begin
               gt_r <= gt_n;
               eq_r <= eq_n;
               if (last) begin
                  a_gt_b   <= gt_n;
                  a_eq_b   <= eq_n;
                  a_lt_b   <= ~gt_n & ~eq_n;
                  nib_used <= m;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            DONE: if (result_ack) begin
               a_gt_b   <= 1'b0;
               a_eq_b   <= 1'b0;
               a_lt_b   <= 1'b0;
               nib_used <= '0;
            end
            default: ;
         endcase
      end
   end

   assign ready        = (state == IDLE);
   assign busy         = (state == RUN);
   assign result_valid = (state == DONE);

endmodule

// File: doc/serial_compare_controller.md
SERIAL_COMPARE_CONTROLLER -- requirements
Module: serial_compare_controller

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; SHALL be a multiple of 4 and >= 4; NIB = WIDTH/4.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request a new comparison; accepted only when ready=1.
REQ-005 a  input  WIDTH  operand A, unsigned; sampled on the accepting edge.
REQ-006 b  input  WIDTH  operand B, unsigned; sampled on the accepting edge.
REQ-007 abort  input  1  cancels a comparison that is in progress.
REQ-008 result_ack  input  1  consumer acknowledges the presented result.
REQ-009 ready  output  1  high only in IDLE.
REQ-010 busy  output  1  high only in RUN.
REQ-011 result_valid  output  1  high only in DONE.
REQ-012 a_gt_b, a_eq_b, a_lt_b  output  1 each  comparison result; exactly one is high while result_valid=1.
REQ-013 nib_used  output  $clog2(NIB)+1  number of nibbles evaluated for the current result.

Function
REQ-014 The block SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-015 IDLE: when start=1, the block SHALL capture a and b into internal registers and clear the cascade to gt=0, eq=1. It SHALL then set the nibble index to NIB-1 and go to RUN.
REQ-016 RUN: on each edge the block SHALL compare one operand nibble, MSB nibble first, using the magnitude-comparator cascade.
- gt_next = gt | (eq & A_nib > B_nib)
- eq_next = eq & (A_nib == B_nib)
- Within a nibble, the same cascade applies bit by bit, MSB first.
REQ-017 RUN SHALL terminate early: after the first nibble for which eq_next=0, the block SHALL go to DONE on that same edge.
REQ-018 RUN SHALL also go to DONE after nibble 0 is evaluated; NIB nibbles is the worst case.
REQ-019 Latency: with m nibbles evaluated (1..NIB), result_valid SHALL rise exactly m edges after the accepting edge.
REQ-020 On entry to DONE the block SHALL register the outputs:
- a_gt_b = gt_next
- a_eq_b = eq_next
- a_lt_b = ~gt_next & ~eq_next
- nib_used = m
REQ-021 The result outputs SHALL hold stable throughout DONE.
REQ-022 DONE: on an edge with result_ack=1, the block SHALL go to IDLE and clear result_valid. A start asserted on that same edge SHALL be ignored, because ready=0 in DONE.
REQ-023 start asserted in RUN or DONE SHALL be ignored; operands SHALL NOT be recaptured.
REQ-024 abort=1 in RUN SHALL return the block to IDLE on the next edge. It SHALL leave all result outputs at 0 and nib_used at 0, and SHALL NOT assert result_valid.
REQ-025 abort SHALL take priority over completion in the same cycle.
REQ-026 abort in IDLE or DONE SHALL have no effect.
REQ-027 The nibble index SHALL never wrap: it SHALL decrement from NIB-1 to 0 only, and the block SHALL leave RUN after index 0.
REQ-028 Changes on a and b after the accepting edge SHALL NOT affect the result.
REQ-029 a_gt_b, a_eq_b, a_lt_b and nib_used SHALL be 0 in IDLE and RUN. After result_ack they SHALL clear to 0 when the block enters IDLE.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for clk, force the following:
- state = IDLE, ready = 1
- busy, result_valid, a_gt_b, a_eq_b, a_lt_b = 0
- nib_used = 0
- operand registers and cascade = 0
REQ-031 A reset asserted mid-RUN or in DONE SHALL discard the comparison with no result presented.
REQ-032 After rst_n deasserts, the first edge with start=1 SHALL be accepted normally.

Verification (WIDTH=16)
REQ-033 Equal operands: a=0xBEEF, b=0xBEEF, start=1 -> busy for 4 cycles; result_valid rises on the 4th edge after acceptance; a_eq_b=1, nib_used=4.
REQ-034 Early termination: a=0x9000, b=0x8FFF -> result_valid on the 1st edge after acceptance; a_gt_b=1, nib_used=1.
REQ-035 Third-nibble difference plus operand hold: a=0x12A4, b=0x12B0, result_ack held low for 5 cycles -> a_lt_b=1 and nib_used=3, stable for all 5 cycles; start pulses during DONE are ignored.
REQ-036 Abort: start with a=0x0001, b=0x0000, then abort=1 on the 2nd RUN cycle -> next edge is IDLE with ready=1; result_valid is never asserted.
REQ-037 Reset mid-operation: rst_n pulled low asynchronously between edges during RUN -> ready=1 and busy=0 immediately. A following start with a=0xFFFF, b=0x0000 yields a_gt_b=1, nib_used=1.
REQ-038 Back-to-back: result_ack=1 and start=1 on the same edge in DONE -> start ignored. start on the next edge (in IDLE) is accepted.
